// File: rtl/load_unit.sv
// Sequential load unit: aligned XLEN-wide memory reads, lane select and extension.
// Define LOAD_UNIT_MISALIGN_EN to service line-crossing loads with a second read.
module load_unit #(
    parameter int XLEN  = 32,
    parameter int AW    = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_addr,
    input  logic [2:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [AW-1:0]    mem_addr,
    input  logic             mem_rsp_valid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);

    localparam int OB = XLEN / 8;
    localparam int OW = $clog2(OB);

    typedef enum logic [2:0] {
        IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP
    } state_t;

    state_t state, state_n;

    logic [AW-1:0]    addr_q;
    logic [2:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  data_q;
    logic             err_q;
    logic [AW-1:0]    aligned;
    logic             illegal_in;
    logic             cross_in;
    logic             reject_in;

    function automatic logic crosses(input logic [OW-1:0] off,
                                     input logic [1:0] sz);
        logic [OW+3:0] sum;
        sum = (OW+4)'(off) + ((OW+4)'(1) << sz);
        return sum > (OW+4)'(OB);
    endfunction

    function automatic logic is_illegal(input logic [2:0] op);
        return (op == 3'b111) ||
               ((XLEN == 32) && ((op == 3'b011) || (op == 3'b110)));
    endfunction

    // Shift the two-word window down to the addressed byte, then extend
    // from the access width; lw on RV32 and ld on RV64 fill the word.
    function automatic logic [XLEN-1:0] assemble(input logic [XLEN-1:0] w0,
                                                 input logic [XLEN-1:0] w1,
                                                 input logic [OW-1:0] off,
                                                 input logic [2:0] op);
        logic [2*XLEN-1:0] cat;
        logic [XLEN-1:0]   res;
        logic              sgn;
        int                nbits;
        cat   = {w1, w0} >> {off, 3'b000};
        nbits = 8 << op[1:0];
        sgn   = !op[2] && cat[nbits-1];
        for (int i = 0; i < XLEN; i++) begin
            res[i] = (i < nbits) ? cat[i] : sgn;
        end
        return res;
    endfunction

    assign aligned    = addr_q & ~AW'(OB - 1);
    assign illegal_in = is_illegal(req_op);
    assign cross_in   = crosses(req_addr[OW-1:0], req_op[1:0]);

`ifdef LOAD_UNIT_MISALIGN_EN
    logic [XLEN-1:0] word0_q;
    logic            cross_q;
    assign cross_q   = crosses(addr_q[OW-1:0], op_q[1:0]);
    assign reject_in = illegal_in;
`else
    assign reject_in = illegal_in || cross_in;
`endif

    always_comb begin
        state_n       = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        rsp_valid     = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = reject_in ? RESP : REQ0;
            end
            REQ0: begin
                mem_req_valid = 1'b1;
                mem_addr      = aligned;
                if (mem_req_ready) state_n = WAIT0;
            end
            WAIT0: begin
`ifdef LOAD_UNIT_MISALIGN_EN
                if (mem_rsp_valid) state_n = cross_q ? REQ1 : RESP;
`else
                if (mem_rsp_valid) state_n = RESP;
`endif
            end
`ifdef LOAD_UNIT_MISALIGN_EN
            REQ1: begin
                mem_req_valid = 1'b1;
                mem_addr      = aligned + AW'(OB);
                if (mem_req_ready) state_n = WAIT1;
            end
            WAIT1: begin
                if (mem_rsp_valid) state_n = RESP;
            end
`endif
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            op_q   <= '0;
            tag_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
`ifdef LOAD_UNIT_MISALIGN_EN
            word0_q <= '0;
`endif
        end else begin
            state <= state_n;
            if (state == IDLE && req_valid) begin
                addr_q <= req_addr;
                op_q   <= req_op;
                tag_q  <= req_tag;
                data_q <= '0;
                err_q  <= reject_in;
`ifdef LOAD_UNIT_MISALIGN_EN
                word0_q <= '0;
`endif
            end
            if (state == WAIT0 && mem_rsp_valid) begin
`ifdef LOAD_UNIT_MISALIGN_EN
                word0_q <= mem_rdata;
                if (!cross_q)
                    data_q <= assemble(mem_rdata, '0, addr_q[OW-1:0], op_q);
`else
                data_q <= assemble(mem_rdata, '0, addr_q[OW-1:0], op_q);
`endif
            end
`ifdef LOAD_UNIT_MISALIGN_EN
            if (state == WAIT1 && mem_rsp_valid)
                data_q <= assemble(word0_q, mem_rdata, addr_q[OW-1:0], op_q);
`endif
        end
    end

    assign rsp_data = data_q;
    assign rsp_tag  = tag_q;
    assign rsp_err  = err_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: RV32 vector table, backpressure, reset, RV64 loads.
module tb_load_unit;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_op;
    logic [4:0]  req_tag;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic        rsp_err;

    logic        auto_rsp, man_rsp;
    logic [31:0] auto_data, man_data;
    assign mem_rsp_valid = auto_rsp | man_rsp;
    assign mem_rdata     = man_rsp ? man_data : auto_data;

    load_unit #(.XLEN(32), .AW(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_op(req_op), .req_tag(req_tag),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    logic        req_valid64, req_ready64;
    logic [31:0] req_addr64;
    logic [2:0]  req_op64;
    logic [4:0]  req_tag64;
    logic        mem_req_valid64, mem_req_ready64;
    logic [31:0] mem_addr64;
    logic        mem_rsp_valid64;
    logic [63:0] mem_rdata64;
    logic        rsp_valid64, rsp_ready64;
    logic [63:0] rsp_data64;
    logic [4:0]  rsp_tag64;
    logic        rsp_err64;

    load_unit #(.XLEN(64), .AW(32), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid64), .req_ready(req_ready64),
        .req_addr(req_addr64), .req_op(req_op64), .req_tag(req_tag64),
        .mem_req_valid(mem_req_valid64), .mem_req_ready(mem_req_ready64),
        .mem_addr(mem_addr64), .mem_rsp_valid(mem_rsp_valid64),
        .mem_rdata(mem_rdata64), .rsp_valid(rsp_valid64),
        .rsp_ready(rsp_ready64), .rsp_data(rsp_data64),
        .rsp_tag(rsp_tag64), .rsp_err(rsp_err64)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // two-word memory image and single-cycle responder
    logic [31:0] ma [2];
    logic [31:0] md [2];
    logic [31:0] addr_log [2];
    int          beats;
    bit          mem_auto;

    initial begin
        auto_rsp  = 1'b0;
        auto_data = '0;
        forever begin
            @(negedge clk);
            if (mem_auto && !rst && mem_req_valid && mem_req_ready) begin
                logic [31:0] a;
                a = mem_addr;
                if (beats < 2) addr_log[beats] = a;
                beats++;
                @(posedge clk);
                #1;
                auto_rsp  = 1'b1;
                auto_data = (a == ma[0]) ? md[0] :
                            (a == ma[1]) ? md[1] : 32'h0;
                @(posedge clk);
                #1;
                auto_rsp = 1'b0;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [2:0] op,
                         input logic [4:0] tag);
        chk("req_ready_before_issue", req_ready, 1'b1);
        req_addr  = a;
        req_op    = op;
        req_tag   = tag;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 1;
        while (!rsp_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic ack;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  op;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] exp_data;
        logic        exp_err;
        int          lat;
        int          nb;
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];

    task automatic run64(input logic [31:0] a, input logic [2:0] op,
                         input logic [63:0] rd, output logic [63:0] data,
                         output logic err, output logic [31:0] maddr);
        int n;
        req_addr64  = a;
        req_op64    = op;
        req_tag64   = 5'd7;
        req_valid64 = 1'b1;
        @(posedge clk);
        #1;
        req_valid64 = 1'b0;
        n = 0;
        while (!mem_req_valid64 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        maddr = mem_addr64;
        @(posedge clk);
        #1;
        mem_rsp_valid64 = 1'b1;
        mem_rdata64     = rd;
        @(posedge clk);
        #1;
        mem_rsp_valid64 = 1'b0;
        n = 0;
        while (!rsp_valid64 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        data = rsp_data64;
        err  = rsp_err64;
        rsp_ready64 = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready64 = 1'b0;
    endtask

    initial begin
        int          n;
        logic [63:0] d64;
        logic        e64;
        logic [31:0] a64;

        vt[0]  = '{32'h103, 3'b000, 32'h80FF1234, 0, 32'hFFFFFF80, 0, 3, 1};
        vt[1]  = '{32'h102, 3'b101, 32'h80010000, 0, 32'h00008001, 0, 3, 1};
        vt[2]  = '{32'h102, 3'b001, 32'h80010000, 0, 32'hFFFF8001, 0, 3, 1};
        vt[4]  = '{32'h000, 3'b011, 32'h12345678, 0, 32'h0, 1, 1, 0};
        vt[5]  = '{32'h000, 3'b111, 32'h12345678, 0, 32'h0, 1, 1, 0};
        vt[6]  = '{32'h000, 3'b110, 32'h12345678, 0, 32'h0, 1, 1, 0};
        vt[7]  = '{32'h101, 3'b100, 32'h80FF1234, 0, 32'h00000012, 0, 3, 1};
        vt[8]  = '{32'h102, 3'b000, 32'h80FF1234, 0, 32'hFFFFFFFF, 0, 3, 1};
        vt[9]  = '{32'h102, 3'b100, 32'h80FF1234, 0, 32'h000000FF, 0, 3, 1};
        vt[10] = '{32'h200, 3'b010, 32'h80000001, 0, 32'h80000001, 0, 3, 1};
        vt[11] = '{32'h301, 3'b001, 32'h00ABCD00, 0, 32'hFFFFABCD, 0, 3, 1};
`ifdef LOAD_UNIT_MISALIGN_EN
        vt[3]  = '{32'h0FE, 3'b010, 32'hAABBCCDD, 32'h11223344,
                   32'h3344AABB, 0, 5, 2};
        vt[12] = '{32'h103, 3'b101, 32'h80FF1234, 32'h0000007F,
                   32'h00007F80, 0, 5, 2};
        vt[13] = '{32'hFFFFFFFE, 3'b010, 32'hAABBCCDD, 32'h11223344,
                   32'h3344AABB, 0, 5, 2};
        vt[14] = '{32'h303, 3'b001, 32'h80000000, 32'h000000FF,
                   32'hFFFFFF80, 0, 5, 2};
`else
        vt[3]  = '{32'h0FE, 3'b010, 32'hAABBCCDD, 32'h11223344, 0, 1, 1, 0};
        vt[12] = '{32'h103, 3'b101, 32'h80FF1234, 32'h0000007F, 0, 1, 1, 0};
        vt[13] = '{32'hFFFFFFFE, 3'b010, 32'hAABBCCDD, 32'h11223344,
                   0, 1, 1, 0};
        vt[14] = '{32'h303, 3'b001, 32'h80000000, 32'h000000FF, 0, 1, 1, 0};
`endif

        rst = 1'b1;
        req_valid = 0; req_addr = 0; req_op = 0; req_tag = 0;
        mem_req_ready = 1'b1; rsp_ready = 1'b0;
        man_rsp = 1'b0; man_data = '0;
        mem_auto = 1'b1; beats = 0;
        req_valid64 = 0; req_addr64 = 0; req_op64 = 0; req_tag64 = 0;
        mem_req_ready64 = 1'b1; mem_rsp_valid64 = 1'b0;
        mem_rdata64 = '0; rsp_ready64 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_mem_req_valid", mem_req_valid, 1'b0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_data", rsp_data, 32'h0);
        chk("reset_rsp_tag", rsp_tag, 5'h0);
        chk("reset_rsp_err", rsp_err, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            ma[0] = vt[i].addr & ~32'h3;
            ma[1] = ma[0] + 32'h4;
            md[0] = vt[i].d0;
            md[1] = vt[i].d1;
            beats = 0;
            issue(vt[i].addr, vt[i].op, 5'(i + 1));
            wait_rsp(n);
            chk($sformatf("v%0d_latency", i), 64'(n), 64'(vt[i].lat));
            chk($sformatf("v%0d_data", i), rsp_data, vt[i].exp_data);
            chk($sformatf("v%0d_err", i), rsp_err, vt[i].exp_err);
            chk($sformatf("v%0d_tag", i), rsp_tag, 5'(i + 1));
            ack();
            chk($sformatf("v%0d_rsp_drop", i), rsp_valid, 1'b0);
            chk($sformatf("v%0d_req_ready", i), req_ready, 1'b1);
            chk($sformatf("v%0d_beats", i), 64'(beats), 64'(vt[i].nb));
            if (vt[i].nb > 0)
                chk($sformatf("v%0d_addr0", i), addr_log[0], ma[0]);
            if (vt[i].nb > 1)
                chk($sformatf("v%0d_addr1", i), addr_log[1], ma[1]);
        end

        // memory and response backpressure
        mem_req_ready = 1'b0;
        ma[0] = 32'h200; ma[1] = 32'h204;
        md[0] = 32'h12345678; md[1] = 32'h0;
        beats = 0;
        issue(32'h200, 3'b010, 5'd9);
        for (int k = 0; k < 3; k++) begin
            chk("bp_mem_req_valid", mem_req_valid, 1'b1);
            chk("bp_mem_addr", mem_addr, 32'h200);
            chk("bp_req_ready", req_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        mem_req_ready = 1'b1;
        wait_rsp(n);
        for (int k = 0; k < 2; k++) begin
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_data", rsp_data, 32'h12345678);
            chk("bp_rsp_tag", rsp_tag, 5'd9);
            chk("bp_req_ready_resp", req_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        ack();
        chk("bp_rsp_drop", rsp_valid, 1'b0);
        chk("bp_req_ready_after", req_ready, 1'b1);
        chk("bp_beats", 64'(beats), 64'd1);

        // reset while waiting for the read data, then a stale response
        mem_auto = 1'b0;
        issue(32'h103, 3'b000, 5'd3);
        @(posedge clk);
        #1;
        chk("rst_in_wait0", mem_req_valid, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_tag", rsp_tag, 5'h0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        man_rsp = 1'b1;
        man_data = 32'h80FF1234;
        @(posedge clk);
        #1;
        man_rsp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stale_rsp_valid", rsp_valid, 1'b0);
            chk("stale_req_ready", req_ready, 1'b1);
            chk("stale_mem_req_valid", mem_req_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        mem_auto = 1'b1;
        ma[0] = 32'h100; ma[1] = 32'h104;
        md[0] = 32'h80FF1234;
        beats = 0;
        issue(32'h103, 3'b000, 5'd4);
        wait_rsp(n);
        chk("post_rst_latency", 64'(n), 64'd3);
        chk("post_rst_data", rsp_data, 32'hFFFFFF80);
        chk("post_rst_tag", rsp_tag, 5'd4);
        chk("post_rst_err", rsp_err, 1'b0);
        ack();

        // RV64 instance
        run64(32'h4, 3'b110, 64'hF000_0001_0000_0000, d64, e64, a64);
        chk("x64_lwu_data", d64, 64'h0000_0000_F000_0001);
        chk("x64_lwu_err", e64, 1'b0);
        chk("x64_lwu_addr", a64, 32'h0);
        run64(32'h4, 3'b010, 64'hF000_0001_0000_0000, d64, e64, a64);
        chk("x64_lw_data", d64, 64'hFFFF_FFFF_F000_0001);
        run64(32'h8, 3'b011, 64'h8000_0000_0000_0001, d64, e64, a64);
        chk("x64_ld_data", d64, 64'h8000_0000_0000_0001);
        chk("x64_ld_addr", a64, 32'h8);
        run64(32'hE, 3'b001, 64'h00AB_0000_0000_0000, d64, e64, a64);
        chk("x64_lh_data", d64, 64'h0000_0000_0000_00AB);
        run64(32'hF, 3'b000, 64'hAB00_0000_0000_0000, d64, e64, a64);
        chk("x64_lb_data", d64, 64'hFFFF_FFFF_FFFF_FFAB);
        chk("x64_lb_addr", a64, 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
